// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and its environment.
//   - Datapath widths (data, opcode, register index)
//   - AluOp encodings of the logic group (msb=1); arithmetic ops keep msb=0
//   - State type of the issue sequencer
// No ports: this is a package.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W    = 8;
    localparam int OP_W      = 4;
    localparam int REG_IDX_W = 2;

    // Logic-group opcodes. The issue stage never decodes these; they are here
    // so the ALU and anything modelling it agree on the encoding.
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1000;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
    localparam logic [OP_W-1:0] OP_LR   = 4'b1100;
    localparam logic [OP_W-1:0] OP_RR   = 4'b1101;

    // IDLE: waiting for a command, EXEC: operands are on the ALU for one
    // cycle, RESP: result is being offered on the response handshake.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_8_regfile.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Small register file for the ALU issue stage: NREGS entries of DATA_W bits,
// two asynchronous read ports and one synchronous write port. Every entry
// returns to RESET_VAL while rst is high.
//
// Ports:
//   clk      in   1          clock, rising edge
//   rst      in   1          asynchronous active-high reset
//   we       in   1          write enable
//   waddr    in   REG_IDX_W  write index
//   wdata    in   DATA_W     write data
//   raddr_a  in   REG_IDX_W  read port A index
//   rdata_a  out  DATA_W     read port A data (combinational)
//   raddr_b  in   REG_IDX_W  read port B index
//   rdata_b  out  DATA_W     read port B data (combinational)
// -----------------------------------------------------------------------------
module regfile_4x8
    import alu_pkg::*;
#(
    parameter int                NREGS     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage: reset clears every entry to RESET_VAL at once; otherwise a
    // single entry is written when we is high. Reads see the value stored
    // before this edge, so a read of the register being written returns the
    // old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_8.sv
// -----------------------------------------------------------------------------
// alu_issue_8
// Sequencing stage in front of the 8-bit combinational ALU. Takes one command
// at a time over a valid/ready handshake, either loading an immediate into the
// register file or issuing registered operands/opcode to the ALU, then writes
// the result back and offers it on a response handshake.
//
// Optional feature: define ALU_ISSUE_ZFLAG_EN to add the RespZero output,
// registered alongside RespData and high when the written value is zero.
//
// Ports:
//   Clk        in   1  clock, rising edge
//   Reset      in   1  asynchronous active-high reset
//   CmdValid   in   1  command present
//   CmdReady   out  1  stage can accept a command (state IDLE)
//   CmdOp      in   4  AluOp to issue
//   CmdLoad    in   1  write CmdImm to CmdDst, bypassing the ALU
//   CmdUseImm  in   1  B operand comes from CmdImm instead of R[CmdSrcB]
//   CmdDst     in   2  destination register index
//   CmdSrcA    in   2  A operand register index
//   CmdSrcB    in   2  B operand register index
//   CmdImm     in   8  immediate value
//   A          out  8  registered ALU operand A
//   B          out  8  registered ALU operand B
//   AluOp      out  4  registered ALU opcode
//   AluResult  in   8  combinational ALU result
//   RespValid  out  1  response valid (state RESP)
//   RespReady  in   1  consumer accepts the response
//   RespData   out  8  value written to the destination register
//   RespDst    out  2  destination index of the response
//   RespZero   out  1  RespData == 0 (only with ALU_ISSUE_ZFLAG_EN)
// -----------------------------------------------------------------------------
module alu_issue_8
    import alu_pkg::*;
#(
    parameter int                NREGS     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
)
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [OP_W-1:0]      CmdOp,
    input  logic                 CmdLoad,
    input  logic                 CmdUseImm,
    input  logic [REG_IDX_W-1:0] CmdDst,
    input  logic [REG_IDX_W-1:0] CmdSrcA,
    input  logic [REG_IDX_W-1:0] CmdSrcB,
    input  logic [DATA_W-1:0]    CmdImm,
    output logic [DATA_W-1:0]    A,
    output logic [DATA_W-1:0]    B,
    output logic [OP_W-1:0]      AluOp,
    input  logic [DATA_W-1:0]    AluResult,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic [DATA_W-1:0]    RespData,
    output logic [REG_IDX_W-1:0] RespDst
`ifdef ALU_ISSUE_ZFLAG_EN
    ,
    output logic                 RespZero
`endif
);

    state_t state;
    state_t next_state;

    logic                 accept;
    logic                 issue_alu;
    logic                 issue_load;
    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic [DATA_W-1:0]    rd_a;
    logic [DATA_W-1:0]    rd_b;
    logic [DATA_W-1:0]    operand_b;
    logic [REG_IDX_W-1:0] dst_q;

    // A command is taken whenever it is offered while idle; loads skip EXEC.
    assign accept     = CmdValid && (state == IDLE);
    assign issue_load = accept && CmdLoad;
    assign issue_alu  = accept && !CmdLoad;

    assign operand_b = CmdUseImm ? CmdImm : rd_b;

    // The register file has a single write port shared by two sources: the
    // immediate of a load on its accept edge, and the ALU result at the end
    // of EXEC. These can never coincide because EXEC is never IDLE.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = CmdDst;
        rf_wdata = CmdImm;
        if (state == EXEC) begin
            rf_we    = 1'b1;
            rf_waddr = dst_q;
            rf_wdata = AluResult;
        end else if (issue_load) begin
            rf_we    = 1'b1;
        end
    end

    regfile_4x8 #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk     (Clk),
        .rst     (Reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (CmdSrcA),
        .rdata_a (rd_a),
        .raddr_b (CmdSrcB),
        .rdata_b (rd_b)
    );

    // State register. Reset drops straight back to IDLE, which abandons any
    // command in flight before it can write back or respond.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. EXEC always lasts exactly one cycle;
    // RESP waits for the consumer, and RespReady is ignored in other states.
    always_comb begin
        next_state = state;
        CmdReady   = 1'b0;
        RespValid  = 1'b0;
        case (state)
            IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) begin
                    next_state = CmdLoad ? RESP : EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                RespValid = 1'b1;
                if (RespReady) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ALU operand registers and response registers. Operands only change on
    // an ALU accept, so they stay put through loads and idle time. The
    // response registers follow every register file write, which keeps
    // RespData/RespDst stable for the whole RESP state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            A        <= '0;
            B        <= '0;
            AluOp    <= '0;
            dst_q    <= '0;
            RespData <= '0;
            RespDst  <= '0;
        end else begin
            if (issue_alu) begin
                A     <= rd_a;
                B     <= operand_b;
                AluOp <= CmdOp;
                dst_q <= CmdDst;
            end
            if (rf_we) begin
                RespData <= rf_wdata;
                RespDst  <= rf_waddr;
            end
        end
    end

`ifdef ALU_ISSUE_ZFLAG_EN
    // Zero flag travels with RespData so it describes the same value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RespZero <= 1'b0;
        end else if (rf_we) begin
            RespZero <= (rf_wdata == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_8.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_8
// Bench for alu_issue_8. Provides a combinational ALU on AluResult, keeps its
// own copy of the register file contents and the last issued operands, and
// checks every transaction (operands in EXEC, response contents, latency,
// backpressure, reset abort) followed by a randomized command stream.
// Define ALU_ISSUE_ZFLAG_EN to also check RespZero.
// -----------------------------------------------------------------------------
module tb_alu_issue_8;
    import alu_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       CmdValid;
    logic       CmdReady;
    logic [3:0] CmdOp;
    logic       CmdLoad;
    logic       CmdUseImm;
    logic [1:0] CmdDst;
    logic [1:0] CmdSrcA;
    logic [1:0] CmdSrcB;
    logic [7:0] CmdImm;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] AluOp;
    logic [7:0] AluResult;
    logic       RespValid;
    logic       RespReady;
    logic [7:0] RespData;
    logic [1:0] RespDst;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic       RespZero;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: what the register file and ALU operand registers
    // should hold, updated from the command stream alone.
    logic [7:0] mreg [4];
    logic [7:0] last_a;
    logic [7:0] last_b;
    logic [3:0] last_op;

    alu_issue_8 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdOp     (CmdOp),
        .CmdLoad   (CmdLoad),
        .CmdUseImm (CmdUseImm),
        .CmdDst    (CmdDst),
        .CmdSrcA   (CmdSrcA),
        .CmdSrcB   (CmdSrcB),
        .CmdImm    (CmdImm),
        .A         (A),
        .B         (B),
        .AluOp     (AluOp),
        .AluResult (AluResult),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespData  (RespData),
        .RespDst   (RespDst)
`ifdef ALU_ISSUE_ZFLAG_EN
        ,
        .RespZero  (RespZero)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU sitting downstream of the stage.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a ^ b;
            4'b0011: return a + 8'd1;
            4'b0100: return a - 8'd1;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NAND: return ~(a & b);
            OP_LR:   return {a[6:0], a[7]};
            OP_RR:   return {a[0], a[7:1]};
            default: return b;
        endcase
    endfunction

    assign AluResult = alu_fn(A, B, AluOp);

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Checks the response outputs while the stage should be in RESP.
    task automatic check_resp(input logic [7:0] exp_data, input logic [1:0] exp_dst);
        checkOutput("resp_valid", {7'd0, RespValid}, 8'd1);
        checkOutput("resp_data", RespData, exp_data);
        checkOutput("resp_dst", {6'd0, RespDst}, {6'd0, exp_dst});
        checkOutput("resp_cmd_ready", {7'd0, CmdReady}, 8'd0);
`ifdef ALU_ISSUE_ZFLAG_EN
        checkOutput("resp_zero", {7'd0, RespZero}, {7'd0, (exp_data == 8'h00)});
`endif
    endtask

    // Presents a command and walks it through to the end of its response,
    // holding RespReady low for bp cycles of RESP first.
    task automatic applyStimulus(input logic load, input logic use_imm, input logic [3:0] op,
                                 input logic [1:0] dst, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [7:0] imm, input int bp);
        logic [7:0] opa;
        logic [7:0] opb;
        logic [7:0] exp_v;
        opa = mreg[sa];
        opb = use_imm ? imm : mreg[sb];
        exp_v = load ? imm : alu_fn(opa, opb, op);

        checkOutput("idle_cmd_ready", {7'd0, CmdReady}, 8'd1);
        CmdValid  = 1'b1;
        CmdLoad   = load;
        CmdUseImm = use_imm;
        CmdOp     = op;
        CmdDst    = dst;
        CmdSrcA   = sa;
        CmdSrcB   = sb;
        CmdImm    = imm;
        RespReady = 1'b0;
        tick();
        CmdValid = 1'b0;
        CmdImm   = 8'($urandom);
        CmdSrcA  = 2'($urandom);
        CmdSrcB  = 2'($urandom);
        if (load) begin
            checkOutput("load_keeps_a", A, last_a);
            checkOutput("load_keeps_b", B, last_b);
            checkOutput("load_keeps_op", {4'd0, AluOp}, {4'd0, last_op});
        end else begin
            checkOutput("exec_a", A, opa);
            checkOutput("exec_b", B, opb);
            checkOutput("exec_op", {4'd0, AluOp}, {4'd0, op});
            checkOutput("exec_resp_valid", {7'd0, RespValid}, 8'd0);
            checkOutput("exec_cmd_ready", {7'd0, CmdReady}, 8'd0);
            last_a  = opa;
            last_b  = opb;
            last_op = op;
            tick();
        end
        for (int i = 0; i < bp; i++) begin
            check_resp(exp_v, dst);
            tick();
        end
        check_resp(exp_v, dst);
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        checkOutput("resp_released", {7'd0, RespValid}, 8'd0);
        checkOutput("ready_after_resp", {7'd0, CmdReady}, 8'd1);
        mreg[dst] = exp_v;
    endtask

    // Reads a register back through the ALU (OR with a zero immediate).
    task automatic readback(input logic [1:0] idx);
        applyStimulus(1'b0, 1'b1, OP_OR, idx, idx, 2'd0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] bp_exp;
        Reset     = 1'b1;
        CmdValid  = 1'b0;
        CmdOp     = 4'd0;
        CmdLoad   = 1'b0;
        CmdUseImm = 1'b0;
        CmdDst    = 2'd0;
        CmdSrcA   = 2'd0;
        CmdSrcB   = 2'd0;
        CmdImm    = 8'd0;
        RespReady = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        last_a  = 8'h00;
        last_b  = 8'h00;
        last_op = 4'h0;

        // Power-on reset
        repeat (3) tick();
        checkOutput("rst_a", A, 8'h00);
        checkOutput("rst_b", B, 8'h00);
        checkOutput("rst_op", {4'd0, AluOp}, 8'h00);
        checkOutput("rst_resp_valid", {7'd0, RespValid}, 8'd0);
        checkOutput("rst_resp_data", RespData, 8'h00);
        checkOutput("rst_resp_dst", {6'd0, RespDst}, 8'h00);
        Reset = 1'b0;
        tick();
        checkOutput("post_rst_ready", {7'd0, CmdReady}, 8'd1);

        // Directed: load, AND issue, immediate OR
        $display("[TB] directed commands");
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 2'd0, 2'd0, 8'hA5, 0);
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 0);
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 2'd0, 2'd0, 8'h3C, 0);
        applyStimulus(1'b0, 1'b0, OP_AND, 2'd2, 2'd0, 2'd1, 8'h00, 0);
        checkOutput("and_result", mreg[2], 8'h30);
        applyStimulus(1'b0, 1'b1, OP_OR, 2'd1, 2'd2, 2'd3, 8'h0F, 0);
        checkOutput("or_imm_result", mreg[1], 8'h3F);
        // Source equal to destination reads the old value
        applyStimulus(1'b0, 1'b1, 4'b0000, 2'd2, 2'd2, 2'd0, 8'h01, 1);

        // Backpressure with a competing command held on the input
        $display("[TB] backpressure");
        bp_exp = alu_fn(mreg[0], mreg[1], 4'b0000);
        CmdValid = 1'b1; CmdLoad = 1'b0; CmdUseImm = 1'b0; CmdOp = 4'b0000;
        CmdDst = 2'd3; CmdSrcA = 2'd0; CmdSrcB = 2'd1;
        tick();
        last_a = mreg[0]; last_b = mreg[1]; last_op = 4'b0000;
        CmdLoad = 1'b1; CmdDst = 2'd2; CmdImm = 8'h77;
        checkOutput("bp_exec_ready", {7'd0, CmdReady}, 8'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_resp(bp_exp, 2'd3);
            tick();
        end
        check_resp(bp_exp, 2'd3);
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        mreg[3] = bp_exp;
        checkOutput("bp_released", {7'd0, RespValid}, 8'd0);
        checkOutput("bp_ready_after", {7'd0, CmdReady}, 8'd1);
        tick();
        CmdValid = 1'b0;
        check_resp(8'h77, 2'd2);
        checkOutput("bp_load_keeps_a", A, last_a);
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        mreg[2] = 8'h77;
        readback(2'd3);

        // NAND producing zero, then a non-zero load
        $display("[TB] zero result");
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd3, 2'd0, 2'd0, 8'hFF, 0);
        applyStimulus(1'b0, 1'b1, OP_NAND, 2'd0, 2'd3, 2'd0, 8'hFF, 0);
        checkOutput("nand_zero", mreg[0], 8'h00);
        applyStimulus(1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 8'h01, 0);

        // Reset in the middle of EXEC aborts the command
        $display("[TB] reset mid-exec");
        CmdValid = 1'b1; CmdLoad = 1'b0; CmdUseImm = 1'b1; CmdOp = 4'b0000;
        CmdDst = 2'd1; CmdSrcA = 2'd1; CmdImm = 8'h11;
        tick();
        CmdValid = 1'b0;
        checkOutput("pre_rst_exec_a", A, mreg[1]);
        Reset = 1'b1;
        #1;
        checkOutput("abort_a", A, 8'h00);
        checkOutput("abort_b", B, 8'h00);
        checkOutput("abort_op", {4'd0, AluOp}, 8'h00);
        checkOutput("abort_resp_valid", {7'd0, RespValid}, 8'd0);
        checkOutput("abort_resp_data", RespData, 8'h00);
        checkOutput("abort_resp_dst", {6'd0, RespDst}, 8'h00);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        last_a = 8'h00; last_b = 8'h00; last_op = 4'h0;
        tick();
        checkOutput("abort_ready", {7'd0, CmdReady}, 8'd1);
        checkOutput("abort_no_resp", {7'd0, RespValid}, 8'd0);
        tick();
        checkOutput("abort_no_resp2", {7'd0, RespValid}, 8'd0);
        for (int i = 0; i < 4; i++) readback(2'(i));

        // Randomized command stream
        $display("[TB] random commands");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(($urandom_range(3) == 0), 1'($urandom), 4'($urandom),
                          2'($urandom), 2'($urandom), 2'($urandom),
                          8'($urandom), int'($urandom_range(2)));
        end
        for (int i = 0; i < 4; i++) readback(2'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
